halut_decoder: RTL



---
 rtl/halut_decoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/halut_decoder.sv
// HALUT decoder: looks up one LUT entry per codebook and accumulates C entries into one row sum.
// Optional ReLU on the emitted sum when HALUT_DECODER_RELU_EN is defined.
module halut_decoder #(
   parameter int unsigned K             = 16,
   parameter int unsigned C             = 32,
   parameter int unsigned DataTypeWidth = 8,
   parameter int unsigned RowCntWidth   = 16,
   parameter int unsigned TreeDepth     = $clog2(K),
   parameter int unsigned CAddrWidth    = $clog2(C),
   parameter int unsigned LutAddrWidth  = $clog2(C * K),
   parameter int unsigned AccWidth      = DataTypeWidth + $clog2(C)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [LutAddrWidth-1:0]  waddr_i,
   input  logic [DataTypeWidth-1:0] wdata_i,
   input  logic                     we_i,
   input  logic [CAddrWidth-1:0]    c_addr_i,
   input  logic [TreeDepth-1:0]     k_addr_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   output logic [AccWidth-1:0]      result_o,
   output logic [RowCntWidth-1:0]   row_o,
   output logic                     valid_o,
   input  logic                     ready_i
);

   logic [DataTypeWidth-1:0] lut_q [C*K];

   logic [DataTypeWidth-1:0] rdata_q;
   logic [CAddrWidth-1:0]    cb_cnt_q, cb_cnt_d;
   logic                     s1_valid_q, s1_valid_d;
   logic                     s1_last_q, s1_last_d;
   logic [AccWidth-1:0]      acc_q, acc_d;
   logic [RowCntWidth-1:0]   row_cnt_q, row_cnt_d;
   logic [AccWidth-1:0]      result_q, result_d;
   logic [RowCntWidth-1:0]   row_q, row_d;
   logic                     valid_q, valid_d;

   logic                     stall;
   logic                     accept;
   logic [LutAddrWidth-1:0]  raddr;
   logic [AccWidth-1:0]      sext;
   logic [AccWidth-1:0]      sum;

   assign raddr   = {c_addr_i, k_addr_i};
   assign stall   = s1_valid_q & s1_last_q & valid_q & ~ready_i;
   assign ready_o = ~stall;
   assign accept  = valid_i & ready_o;
   assign sext    = {{(AccWidth - DataTypeWidth){rdata_q[DataTypeWidth-1]}}, rdata_q};
   assign sum     = acc_q + sext;

   // LUT is plain storage without reset; a same-address read this edge still sees the old word.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         lut_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      cb_cnt_d   = cb_cnt_q;
      s1_valid_d = s1_valid_q;
      s1_last_d  = s1_last_q;
      acc_d      = acc_q;
      row_cnt_d  = row_cnt_q;
      result_d   = result_q;
      row_d      = row_q;
      valid_d    = valid_q;

      if (accept) begin
         cb_cnt_d   = cb_cnt_q + 1'b1;
         s1_valid_d = 1'b1;
         s1_last_d  = (cb_cnt_q == CAddrWidth'(C - 1));
      end else if (!stall) begin
         s1_valid_d = 1'b0;
      end

      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      // acc is zero at every row start, so acc + sext equals sext for the first entry.
      if (s1_valid_q && !stall) begin
         if (s1_last_q) begin
            acc_d     = '0;
`ifdef HALUT_DECODER_RELU_EN
            result_d  = sum[AccWidth-1] ? '0 : sum;
`else
            result_d  = sum;
`endif
            row_d     = row_cnt_q;
            valid_d   = 1'b1;
            row_cnt_d = row_cnt_q + 1'b1;
         end else begin
            acc_d = sum;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q    <= '0;
         cb_cnt_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         acc_q      <= '0;
         row_cnt_q  <= '0;
         result_q   <= '0;
         row_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         if (accept) begin
            rdata_q <= lut_q[raddr];
         end
         cb_cnt_q   <= cb_cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_last_q  <= s1_last_d;
         acc_q      <= acc_d;
         row_cnt_q  <= row_cnt_d;
         result_q   <= result_d;
         row_q      <= row_d;
         valid_q    <= valid_d;
      end
   end

   assign result_o = result_q;
   assign row_o    = row_q;
   assign valid_o  = valid_q;

endmodule
